// File: rtl/sd_spi_cmd_responder.sv
// SPI-mode SD card command responder (optional CRC7 frame check under SDCMD_CRC_CHECK_EN).
// First response byte goes out NCR+1 byte slots after the CRC byte; paced only by rx_valid_i, cs_n_i high aborts.
module sd_spi_cmd_responder #(
    parameter int          NCR            = 1,
    parameter int          ACMD41_RETRIES = 2,
    parameter logic [31:0] OCR            = 32'h40FF8000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        cs_n_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_byte_i,
    output logic [7:0]  tx_byte_o,
    output logic        cmd_valid_o,
    output logic [5:0]  cmd_index_o,
    output logic [31:0] cmd_arg_o,
    output logic        in_idle_o,
    output logic        busy_o
);
    typedef enum logic [2:0] {HUNT, COLLECT, EXEC, NCR_WAIT, RESP} state_t;

    localparam logic [2:0] NCR_N = 3'(NCR);
    localparam logic [3:0] RET_N = 4'(ACMD41_RETRIES);

    state_t      state_q;
    logic [7:0]  tx_q;
    logic        cmd_valid_q, in_idle_q, busy_q, app_q;
    logic [5:0]  cmd_index_q, fidx_q;
    logic [31:0] cmd_arg_q, farg_q;
    logic [3:0]  a41_cnt_q;
    logic [2:0]  bcnt_q, rem_q, ncr_q;
    logic [39:0] resp_q;

    logic        accept_d, idle_d, app_d, illegal_d, crc_err_d;
    logic [3:0]  cnt_d, a41_inc;
    logic [7:0]  r1_d;
    logic [39:0] resp_d;
    logic [2:0]  len_d;

`ifdef SDCMD_CRC_CHECK_EN
    logic [7:0] fcrc_q;

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction
`endif

    // Effect and response of the captured frame, consumed in EXEC.
    always_comb begin
        a41_inc   = (a41_cnt_q == 4'hF) ? 4'hF : a41_cnt_q + 4'd1;
        accept_d  = 1'b1;
        illegal_d = 1'b0;
        crc_err_d = 1'b0;
        idle_d    = in_idle_q;
        cnt_d     = a41_cnt_q;
        app_d     = 1'b0;
`ifdef SDCMD_CRC_CHECK_EN
        crc_err_d = (fcrc_q != {crc7({2'b01, fidx_q, farg_q}), 1'b1});
`endif
        if (crc_err_d) begin
            accept_d = 1'b0;
            app_d    = app_q;
        end else begin
            case (fidx_q)
                6'd0: begin
                    idle_d = 1'b1;
                    cnt_d  = 4'd0;
                end
                6'd8, 6'd16, 6'd58: ;
                6'd55: app_d = 1'b1;
                6'd41: begin
                    if (app_q) begin
                        cnt_d = a41_inc;
                        if (a41_inc == RET_N) idle_d = 1'b0;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
                default: illegal_d = 1'b1;
            endcase
        end
        r1_d   = {4'b0000, crc_err_d, illegal_d, 1'b0, idle_d};
        resp_d = {r1_d, 32'hFFFF_FFFF};
        len_d  = 3'd1;
        if (!crc_err_d && fidx_q == 6'd8) begin
            resp_d = {r1_d, 16'h0000, 4'h0, farg_q[11:0]};
            len_d  = 3'd5;
        end else if (!crc_err_d && fidx_q == 6'd58) begin
            resp_d = {r1_d, ~idle_d, OCR[30:0]};
            len_d  = 3'd5;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= HUNT;
            tx_q        <= 8'hFF;
            cmd_valid_q <= 1'b0;
            cmd_index_q <= '0;
            cmd_arg_q   <= '0;
            in_idle_q   <= 1'b1;
            busy_q      <= 1'b0;
            app_q       <= 1'b0;
            a41_cnt_q   <= '0;
            fidx_q      <= '0;
            farg_q      <= '0;
            bcnt_q      <= '0;
            rem_q       <= '0;
            ncr_q       <= '0;
            resp_q      <= '1;
`ifdef SDCMD_CRC_CHECK_EN
            fcrc_q      <= '0;
`endif
        end else begin
            cmd_valid_q <= 1'b0;
            if (cs_n_i) begin
                state_q <= HUNT;
                tx_q    <= 8'hFF;
                busy_q  <= 1'b0;
                bcnt_q  <= '0;
            end else begin
                case (state_q)
                    HUNT: if (rx_valid_i && rx_byte_i[7:6] == 2'b01) begin
                        fidx_q  <= rx_byte_i[5:0];
                        busy_q  <= 1'b1;
                        bcnt_q  <= '0;
                        state_q <= COLLECT;
                    end
                    COLLECT: if (rx_valid_i) begin
                        if (bcnt_q == 3'd4) begin
`ifdef SDCMD_CRC_CHECK_EN
                            fcrc_q <= rx_byte_i;
`endif
                            state_q <= EXEC;
                        end else begin
                            farg_q <= {farg_q[23:0], rx_byte_i};
                            bcnt_q <= bcnt_q + 3'd1;
                        end
                    end
                    EXEC: begin
                        in_idle_q <= idle_d;
                        a41_cnt_q <= cnt_d;
                        app_q     <= app_d;
                        if (accept_d) begin
                            cmd_valid_q <= 1'b1;
                            cmd_index_q <= fidx_q;
                            cmd_arg_q   <= farg_q;
                        end
                        if (NCR_N == 3'd0) begin
                            tx_q    <= resp_d[39:32];
                            resp_q  <= {resp_d[31:0], 8'hFF};
                            rem_q   <= len_d - 3'd1;
                            state_q <= RESP;
                        end else begin
                            tx_q    <= 8'hFF;
                            resp_q  <= resp_d;
                            rem_q   <= len_d;
                            ncr_q   <= NCR_N;
                            state_q <= NCR_WAIT;
                        end
                    end
                    NCR_WAIT: if (rx_valid_i) begin
                        if (ncr_q == 3'd1) begin
                            tx_q    <= resp_q[39:32];
                            resp_q  <= {resp_q[31:0], 8'hFF};
                            rem_q   <= rem_q - 3'd1;
                            state_q <= RESP;
                        end else begin
                            ncr_q <= ncr_q - 3'd1;
                        end
                    end
                    RESP: if (rx_valid_i) begin
                        if (rem_q != 3'd0) begin
                            tx_q   <= resp_q[39:32];
                            resp_q <= {resp_q[31:0], 8'hFF};
                            rem_q  <= rem_q - 3'd1;
                        end else begin
                            tx_q    <= 8'hFF;
                            busy_q  <= 1'b0;
                            state_q <= HUNT;
                        end
                    end
                    default: state_q <= HUNT;
                endcase
            end
        end
    end

    assign tx_byte_o   = tx_q;
    assign cmd_valid_o = cmd_valid_q;
    assign cmd_index_o = cmd_index_q;
    assign cmd_arg_o   = cmd_arg_q;
    assign in_idle_o   = in_idle_q;
    assign busy_o      = busy_q;
endmodule

// File: tb/tb_sd_spi_cmd_responder.sv
// Bench for sd_spi_cmd_responder: directed card-init sequences plus random frames, checked by a
// byte-slot reference model through decoupled scoreboard queues.
module tb_sd_spi_cmd_responder;
    localparam int          NCR = 1;
    localparam int          RET = 2;
    localparam logic [31:0] OCR = 32'h40FF8000;

    logic        clk = 1'b0;
    logic        reset, cs_n, rx_valid;
    logic [7:0]  rx_byte;
    logic [7:0]  tx_byte;
    logic        cmd_valid, in_idle, busy;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;

    always #5 clk = ~clk;

    sd_spi_cmd_responder #(.NCR(NCR), .ACMD41_RETRIES(RET), .OCR(OCR)) dut (
        .clk_i(clk), .reset_i(reset), .cs_n_i(cs_n), .rx_valid_i(rx_valid), .rx_byte_i(rx_byte),
        .tx_byte_o(tx_byte), .cmd_valid_o(cmd_valid), .cmd_index_o(cmd_index),
        .cmd_arg_o(cmd_arg), .in_idle_o(in_idle), .busy_o(busy)
    );

    int total = 0;
    int passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    typedef struct { logic [7:0] tx; logic busy; } slot_t;
    typedef struct { logic [5:0] idx; logic [31:0] arg; logic idle; } cmd_t;
    slot_t      exp_slot_q[$];
    cmd_t       exp_cmd_q[$];

    // Reference card: bytes still owed to the host are simply a queue of future slots.
    logic [7:0] frame[$];
    logic [7:0] outq[$];
    logic       m_idle = 1'b1;
    logic       m_app  = 1'b0;
    int         m_cnt  = 0;

    function automatic logic [6:0] crc7_ref(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    task automatic model_exec();
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [31:0] ocr;
        logic        illegal, crc_err;
        logic [7:0]  r1;
        idx     = frame[0][5:0];
        arg     = {frame[1], frame[2], frame[3], frame[4]};
        crc_err = 1'b0;
`ifdef SDCMD_CRC_CHECK_EN
        crc_err = (frame[5] != {crc7_ref({frame[0], arg}), 1'b1});
`endif
        frame.delete();
        for (int i = 0; i < NCR; i++) outq.push_back(8'hFF);
        if (crc_err) begin
            outq.push_back(8'h08 + (m_idle ? 8'h01 : 8'h00));
            return;
        end
        illegal = 1'b0;
        if (idx == 0) begin
            m_idle = 1'b1;
            m_cnt  = 0;
        end else if (idx == 41 && m_app) begin
            if (m_cnt < 15) m_cnt = m_cnt + 1;
            if (m_cnt == RET) m_idle = 1'b0;
        end else if (!(idx == 8 || idx == 16 || idx == 55 || idx == 58)) begin
            illegal = 1'b1;
        end
        m_app = (idx == 55);
        exp_cmd_q.push_back('{idx, arg, m_idle});
        r1 = (illegal ? 8'h04 : 8'h00) + (m_idle ? 8'h01 : 8'h00);
        outq.push_back(r1);
        if (idx == 8) begin
            outq.push_back(8'h00);
            outq.push_back(8'h00);
            outq.push_back({4'h0, arg[11:8]});
            outq.push_back(arg[7:0]);
        end else if (idx == 58) begin
            ocr = {~m_idle, OCR[30:0]};
            for (int i = 3; i >= 0; i--) outq.push_back(ocr[8*i +: 8]);
        end
    endtask

    task automatic model_rx(input logic [7:0] b);
        slot_t s;
        logic  responding;
        responding = (outq.size() > 0);
        s.busy = (frame.size() > 0) || responding;
        s.tx   = responding ? outq.pop_front() : 8'hFF;
        exp_slot_q.push_back(s);
        if (responding) return;
        if (frame.size() == 0 && b[7:6] != 2'b01) return;
        frame.push_back(b);
        if (frame.size() == 6) model_exec();
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1;
        cs_n     = 1'b0;
        rx_valid = 1'b1;
        rx_byte  = b;
        model_rx(b);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crcb);
        send({2'b01, idx});
        for (int i = 3; i >= 0; i--) send(arg[8*i +: 8]);
        send(crcb);
    endtask

    function automatic logic [7:0] good_crc(input logic [5:0] idx, input logic [31:0] arg);
        return {crc7_ref({2'b01, idx, arg}), 1'b1};
    endfunction

    task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg);
        send_frame(idx, arg, good_crc(idx, arg));
    endtask

    task automatic drain();
        while (outq.size() > 0) send(8'($urandom));
    endtask

    task automatic abort();
        @(posedge clk);
        #1;
        cs_n = 1'b1;
        frame.delete();
        outq.delete();
        repeat (2) @(posedge clk);
        #1;
        check("abort_tx", tx_byte, 8'hFF);
        check("abort_busy", busy, 1'b0);
    endtask

    always @(negedge clk) begin
        if (!reset && rx_valid && !cs_n) begin
            if (exp_slot_q.size() == 0) begin
                check("slot_unexpected", 1'b1, 1'b0);
            end else begin
                slot_t s;
                s = exp_slot_q.pop_front();
                check("slot_tx", tx_byte, s.tx);
                check("slot_busy", busy, s.busy);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && cmd_valid) begin
            if (exp_cmd_q.size() == 0) begin
                check("cmd_valid_unexpected", 1'b1, 1'b0);
            end else begin
                cmd_t c;
                c = exp_cmd_q.pop_front();
                check("cmd_index", cmd_index, c.idx);
                check("cmd_arg", cmd_arg, c.arg);
                check("cmd_in_idle", in_idle, c.idle);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cs_n = 1'b1; rx_valid = 1'b0; rx_byte = 8'hFF;
        repeat (2) @(negedge clk);
        check("rst_tx", tx_byte, 8'hFF);
        check("rst_cmd_valid", cmd_valid, 1'b0);
        check("rst_index", cmd_index, 6'd0);
        check("rst_arg", cmd_arg, 32'd0);
        check("rst_idle", in_idle, 1'b1);
        check("rst_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        send_frame(6'd0, 32'h0, 8'h95);           drain();
        send_frame(6'd8, 32'h0000_01AA, 8'h87);   drain();
        for (int i = 0; i < 2; i++) begin
            send_cmd(6'd55, 32'h0);               drain();
            send_cmd(6'd41, 32'h4000_0000);       drain();
        end
        check("idle_after_acmd41", in_idle, 1'b0);
        send_cmd(6'd58, 32'h0);                   drain();
        send_cmd(6'd0, 32'h0);                    drain();
        send_cmd(6'd41, 32'h4000_0000);           drain();
        send_cmd(6'd17, 32'h0000_0200);           drain();
        check("idle_after_illegal", in_idle, 1'b1);

        send(8'h48); send(8'h00); send(8'h00);
        abort();
        send_frame(6'd0, 32'h0, 8'h95);           drain();

`ifdef SDCMD_CRC_CHECK_EN
        send_frame(6'd0, 32'h0, 8'h94);           drain();
        send_frame(6'd0, 32'h0, 8'h95);           drain();
`endif

        send_frame(6'd8, 32'h0000_01AA, 8'h87);
        send(8'hFF); send(8'hFF);
        @(posedge clk);
        #1;
        reset = 1'b1;
        frame.delete(); outq.delete();
        m_idle = 1'b1; m_app = 1'b0; m_cnt = 0;
        @(negedge clk);
        check("midresp_rst_tx", tx_byte, 8'hFF);
        check("midresp_rst_busy", busy, 1'b0);
        check("midresp_rst_idle", in_idle, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int n = 0; n < 80; n++) begin
            logic [5:0]  idx;
            logic [31:0] arg;
            logic [7:0]  crcb;
            case ($urandom_range(0, 7))
                0: idx = 6'd0;
                1: idx = 6'd8;
                2, 3: idx = 6'd55;
                4: idx = 6'd41;
                5: idx = 6'd58;
                6: idx = 6'd16;
                default: idx = 6'($urandom);
            endcase
            arg  = $urandom;
            crcb = good_crc(idx, arg);
            if ($urandom_range(0, 5) == 0) crcb = crcb ^ 8'(1 << $urandom_range(1, 7));
            if ($urandom_range(0, 9) == 0) begin
                send({2'b01, idx});
                for (int k = $urandom_range(0, 4); k > 0; k--) send(8'($urandom));
                abort();
            end else begin
                send_frame(idx, arg, crcb);
                drain();
                for (int k = $urandom_range(0, 2); k > 0; k--) send(8'($urandom_range(0, 63)) | 8'h80);
            end
        end

        repeat (4) @(posedge clk);
        check("slot_q_empty", 64'(exp_slot_q.size()), 64'd0);
        check("cmd_q_empty", 64'(exp_cmd_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
